blk_9a2448: RTL and testbench

VIDEO_DRAM_DATA_SELECTOR_AND_CONTROL_LATCHES_GEN2 -- requirements
Module: video_dram_data_selector_and_control_latches_gen2

---
 rtl/blk_9a2448.sv | 153 +++++++++++++++
 tb/tb_blk_9a2448.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/blk_9a2448.sv
// blk_9a2448 -- video DRAM data selector and control latches.
//
// Purpose:
//   Builds the registered DRAM write word DX. Each plane comes either from the
//   CPU bus (sliced so plane p takes CPU slice p mod (DW/PW)) or from the
//   pixel bus. A fill engine can replace DX with a captured CPU pattern for a
//   programmed number of cycles. Two edge-triggered latches hold the halftone
//   enables and the layer priority, enable and bank-select bits.
//
// Ports:
//   CLK          in   system clock, all state on the rising edge
//   RST          in   synchronous active-high reset
//   HFEN         in   halftone latch write strobe (loads on its rising edge)
//   I_II_EN_PRI  in   control latch write strobe (loads on its rising edge)
//   EXCT         in   data select: 0 = CPU data, 1 = pixel data
//   DB           in   CPU data bus [DW]
//   DP           in   pixel data, plane p at [p*PW +: PW]
//   FILL_START   in   single-cycle fill request
//   FILL_COUNT   in   fill length in cycles [CW]
//   DX           out  registered DRAM write data, packed like DP
//   HF_AL        out  active-low halftone enables, bit 3*l+c (c: 0=B 1=G 2=R)
//   PRI_AL       out  active-low layer priority [LAYERS]
//   EN           out  layer enable [LAYERS]
//   SEL_I_II_AL  out  active-low bank select [LAYERS]
//   FILL_BUSY    out  high while the fill pattern drives DX
module blk_9a2448 #(
  parameter int PLANES = 4,
  parameter int PW     = 4,
  parameter int DW     = 8,
  parameter int LAYERS = 2,
  parameter int CW     = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   HFEN,
  input  logic                   I_II_EN_PRI,
  input  logic                   EXCT,
  input  logic [DW-1:0]          DB,
  input  logic [PLANES*PW-1:0]   DP,
  input  logic                   FILL_START,
  input  logic [CW-1:0]          FILL_COUNT,
  output logic [PLANES*PW-1:0]   DX,
  output logic [3*LAYERS-1:0]    HF_AL,
  output logic [LAYERS-1:0]      PRI_AL,
  output logic [LAYERS-1:0]      EN,
  output logic [LAYERS-1:0]      SEL_I_II_AL,
  output logic                   FILL_BUSY
);

  localparam int SLICES = DW / PW;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]           state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [DW-1:0]        pat_reg;
  logic [PLANES*PW-1:0] dx_reg;
  logic                 busy_reg;
  logic [3*LAYERS-1:0]  hf_al_reg;
  logic [LAYERS-1:0]    pri_al_reg;
  logic [LAYERS-1:0]    en_reg;
  logic [LAYERS-1:0]    sel_al_reg;
  logic                 hfen_prev_reg;
  logic                 ctl_prev_reg;

  logic [PLANES*PW-1:0] cpu_planes;
  logic [PLANES*PW-1:0] pat_planes;
  logic [PLANES*PW-1:0] normal_sel;
  logic                 hf_load;
  logic                 ctl_load;
  logic                 fill_go;

  // Replicate the CPU bus (and the captured fill pattern) across planes:
  // plane p takes slice p mod SLICES.
  for (genvar gi = 0; gi < PLANES; gi++) begin : g_slice
    localparam int K = gi % SLICES;
    assign cpu_planes[gi*PW +: PW] = DB[K*PW +: PW];
    assign pat_planes[gi*PW +: PW] = pat_reg[K*PW +: PW];
  end

  assign normal_sel = EXCT ? DP : cpu_planes;

  // Load only on a 0->1 transition of each strobe; the prev flops come out of
  // reset high so a strobe already high at reset release does not load.
  assign hf_load  = HFEN & ~hfen_prev_reg;
  assign ctl_load = I_II_EN_PRI & ~ctl_prev_reg;

  // A zero-length fill request is treated as no request at all.
  assign fill_go  = FILL_START && (FILL_COUNT != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      pat_reg       <= '0;
      dx_reg        <= '0;
      busy_reg      <= 1'b0;
      hf_al_reg     <= '1;
      pri_al_reg    <= '1;
      en_reg        <= '0;
      sel_al_reg    <= '1;
      hfen_prev_reg <= 1'b1;
      ctl_prev_reg  <= 1'b1;
    end else begin
      hfen_prev_reg <= HFEN;
      ctl_prev_reg  <= I_II_EN_PRI;

      // Control latches run independently of the fill engine.
      if (hf_load) begin
        hf_al_reg <= DB[3*LAYERS-1:0];
      end
      if (ctl_load) begin
        pri_al_reg <= DB[LAYERS-1:0];
        en_reg     <= DB[2*LAYERS-1:LAYERS];
        sel_al_reg <= DB[3*LAYERS-1:2*LAYERS];
      end

      if (state_reg == IDLE) begin
        if (fill_go) begin
          // The pattern is taken straight off the bus this cycle so DX shows
          // it on the very next edge.
          pat_reg   <= DB;
          cnt_reg   <= FILL_COUNT;
          dx_reg    <= cpu_planes;
          busy_reg  <= 1'b1;
          state_reg <= FILL;
        end else begin
          dx_reg <= normal_sel;
        end
      end else begin
        // FILL_START is deliberately not looked at here.
        if (cnt_reg == CW'(1)) begin
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          dx_reg    <= normal_sel;
          state_reg <= IDLE;
        end else begin
          cnt_reg <= cnt_reg - CW'(1);
          dx_reg  <= pat_planes;
        end
      end
    end
  end

  assign DX          = dx_reg;
  assign HF_AL       = hf_al_reg;
  assign PRI_AL      = pri_al_reg;
  assign EN          = en_reg;
  assign SEL_I_II_AL = sel_al_reg;
  assign FILL_BUSY   = busy_reg;

endmodule

// File: tb/tb_blk_9a2448.sv
// tb_blk_9a2448 -- directed bench for blk_9a2448 with default parameters.
module tb_blk_9a2448;

  logic        clk;
  logic        rst;
  logic        hfen;
  logic        ctl;
  logic        exct;
  logic [7:0]  db;
  logic [15:0] dp;
  logic        fill_start;
  logic [7:0]  fill_count;
  logic [15:0] dx;
  logic [5:0]  hf_al;
  logic [1:0]  pri_al;
  logic [1:0]  en;
  logic [1:0]  sel_al;
  logic        fill_busy;

  int checks = 0;
  int errors = 0;

  blk_9a2448 dut (
    .CLK         (clk),
    .RST         (rst),
    .HFEN        (hfen),
    .I_II_EN_PRI (ctl),
    .EXCT        (exct),
    .DB          (db),
    .DP          (dp),
    .FILL_START  (fill_start),
    .FILL_COUNT  (fill_count),
    .DX          (dx),
    .HF_AL       (hf_al),
    .PRI_AL      (pri_al),
    .EN          (en),
    .SEL_I_II_AL (sel_al),
    .FILL_BUSY   (fill_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        exct;
    logic [7:0]  db;
    logic [15:0] dp;
    logic [15:0] exp_dx;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Advance one edge, then move to the sampling point on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int busy_cycles;

    vecs[0] = '{1'b0, 8'hA5, 16'h0000, 16'hA5A5};
    vecs[1] = '{1'b1, 8'hA5, 16'h1234, 16'h1234};
    vecs[2] = '{1'b0, 8'h3C, 16'hFFFF, 16'h3C3C};
    vecs[3] = '{1'b1, 8'h00, 16'hBEEF, 16'hBEEF};
    vecs[4] = '{1'b0, 8'h7E, 16'h0F0F, 16'h7E7E};
    vecs[5] = '{1'b0, 8'h01, 16'h0000, 16'h0101};

    // Reset with HFEN already high so its release must not load.
    rst = 1'b1; hfen = 1'b1; ctl = 1'b0; exct = 1'b0; db = 8'h12;
    dp = 16'h0; fill_start = 1'b0; fill_count = 8'd0;
    @(negedge clk); step(); step();
    check("rst_dx",     32'(dx), 32'h0);
    check("rst_hf_al",  32'(hf_al), 32'h3F);
    check("rst_pri_al", 32'(pri_al), 32'h3);
    check("rst_en",     32'(en), 32'h0);
    check("rst_sel_al", 32'(sel_al), 32'h3);
    check("rst_busy",   32'(fill_busy), 32'h0);
    rst = 1'b0;
    step(); step(); step();
    check("hfen_across_reset_hf_al", 32'(hf_al), 32'h3F);
    hfen = 1'b0;
    step();

    // Select path table.
    for (int i = 0; i < 6; i++) begin
      exct = vecs[i].exct; db = vecs[i].db; dp = vecs[i].dp;
      step();
      check($sformatf("sel_vec%0d_dx", i), 32'(dx), 32'(vecs[i].exp_dx));
    end
    exct = 1'b0;

    // Halftone latch: held high 5 cycles, bus changes mid-hold.
    db = 8'h2A; hfen = 1'b1;
    step();
    check("hf_load_2a", 32'(hf_al), 32'h2A);
    db = 8'h15;
    for (int i = 0; i < 4; i++) step();
    check("hf_hold_ignores_db", 32'(hf_al), 32'h2A);
    hfen = 1'b0;
    step();

    // Control latch pulse.
    db = 8'h39; ctl = 1'b1;
    step();
    ctl = 1'b0;
    check("ctl_pri_al", 32'(pri_al), 32'h1);
    check("ctl_en",     32'(en), 32'h2);
    check("ctl_sel_al", 32'(sel_al), 32'h3);
    step();

    // Both strobes rise together.
    db = 8'h0F; hfen = 1'b1; ctl = 1'b1;
    step();
    hfen = 1'b0; ctl = 1'b0;
    check("both_hf_al",  32'(hf_al), 32'h0F);
    check("both_pri_al", 32'(pri_al), 32'h3);
    check("both_en",     32'(en), 32'h3);
    check("both_sel_al", 32'(sel_al), 32'h0);
    step();

    // Fill of 3 cycles, with a second request and a control load inside it.
    exct = 1'b0; db = 8'h3C; fill_start = 1'b1; fill_count = 8'd3;
    step();
    fill_start = 1'b0; db = 8'h11;
    check("fill_c1_dx",   32'(dx), 32'h3C3C);
    check("fill_c1_busy", 32'(fill_busy), 32'h1);
    fill_start = 1'b1; fill_count = 8'd5; db = 8'h22; ctl = 1'b1;
    step();
    fill_start = 1'b0; db = 8'h11; ctl = 1'b0;
    check("fill_c2_dx",     32'(dx), 32'h3C3C);
    check("fill_c2_busy",   32'(fill_busy), 32'h1);
    check("fill_ctl_pri",   32'(pri_al), 32'h2);
    check("fill_ctl_en",    32'(en), 32'h0);
    check("fill_ctl_sel",   32'(sel_al), 32'h2);
    step();
    check("fill_c3_dx",   32'(dx), 32'h3C3C);
    check("fill_c3_busy", 32'(fill_busy), 32'h1);
    step();
    check("fill_end_dx",   32'(dx), 32'h1111);
    check("fill_end_busy", 32'(fill_busy), 32'h0);
    exct = 1'b1; dp = 16'hCAFE;
    step();
    check("fill_after_dx",   32'(dx), 32'hCAFE);
    check("fill_after_busy", 32'(fill_busy), 32'h0);
    exct = 1'b0;

    // Zero-length fill request is a no-op.
    db = 8'h55; fill_start = 1'b1; fill_count = 8'd0;
    step();
    fill_start = 1'b0;
    check("zero_fill_busy", 32'(fill_busy), 32'h0);
    check("zero_fill_dx",   32'(dx), 32'h5555);
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fill_busy) busy_cycles++;
    end
    check("zero_fill_busy_cycles", 32'(busy_cycles), 32'h0);

    // Maximum fill length: busy for exactly 255 cycles, bounded at 300.
    db = 8'h96; fill_start = 1'b1; fill_count = 8'd255;
    step();
    fill_start = 1'b0; db = 8'h00;
    busy_cycles = 0;
    for (int i = 0; i < 300 && fill_busy; i++) begin
      busy_cycles++;
      step();
    end
    check("max_fill_cycles", 32'(busy_cycles), 32'd255);
    check("max_fill_end_dx", 32'(dx), 32'h0000);

    // Reset during fill, with HFEN high across the release.
    db = 8'h3C; fill_start = 1'b1; fill_count = 8'd10;
    step();
    fill_start = 1'b0;
    step();
    check("rstfill_busy_before", 32'(fill_busy), 32'h1);
    rst = 1'b1; hfen = 1'b1;
    step();
    check("rstfill_dx",    32'(dx), 32'h0);
    check("rstfill_busy",  32'(fill_busy), 32'h0);
    check("rstfill_hf_al", 32'(hf_al), 32'h3F);
    rst = 1'b0; db = 8'h07;
    step(); step();
    check("rstfill_hfen_held_hf_al", 32'(hf_al), 32'h3F);
    check("rstfill_idle_dx", 32'(dx), 32'h0707);
    hfen = 1'b0;
    step();
    hfen = 1'b1;
    step();
    hfen = 1'b0;
    check("hf_reload_after_fall", 32'(hf_al), 32'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
